serial_mag_comp: RTL and testbench

//  Bit-serial N-bit magnitude comparator built around the one-bit compare cell.

---
 rtl/serial_mag_comp.sv | 150 +++++++++++++++
 tb/tb_serial_mag_comp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first magnitude comparator with valid/ready handshakes
// Operands shift through one single-bit compare cell; the first differing bit decides the result.

module serial_mag_comp_bit (
    input  logic a_i,
    input  logic b_i,
    output logic lt_o,
    output logic gt_o,
    output logic eq_o
);
    assign lt_o = ~a_i & b_i;
    assign gt_o = a_i & ~b_i;
    assign eq_o = ~(a_i ^ b_i);
endmodule

module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_a_q, sr_a_d;
    logic [WIDTH-1:0] sr_b_q, sr_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic bit_lt, bit_gt, bit_eq;

    serial_mag_comp_bit u_cell (
        .a_i  (sr_a_q[WIDTH-1]),
        .b_i  (sr_b_q[WIDTH-1]),
        .lt_o (bit_lt),
        .gt_o (bit_gt),
        .eq_o (bit_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_a_q    <= '0;
            sr_b_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            sr_a_q    <= sr_a_d;
            sr_b_q    <= sr_b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_a_d    = sr_a_q;
        sr_b_d    = sr_b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        cycles_d  = cycles_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_a_d    = a;
                    sr_b_d    = b;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_a_d = {sr_a_q[WIDTH-2:0], 1'b0};
                sr_b_d = {sr_b_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CW'(1);
                // Only the first differing bit matters; later bits cannot change the order.
                if (!decided_q && !bit_eq) begin
                    lt_d      = bit_lt;
                    gt_d      = bit_gt;
                    eq_d      = 1'b0;
                    decided_d = 1'b1;
                    if (EARLY_EXIT != 0) begin
                        state_d  = DONE;
                        cycles_d = cnt_d;
                    end
                end
                if (state_d == SHIFT && cnt_d == LAST) begin
                    state_d  = DONE;
                    cycles_d = cnt_d;
                    if (!decided_d) begin
                        lt_d = 1'b0;
                        gt_d = 1'b0;
                        eq_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = lt_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - scoreboard bench driving an early-exit and a full-length comparator in parallel
// Stimulus pushes expected results; a negedge monitor pops and checks whenever out_valid is seen.

module tb_serial_mag_comp;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic          in_ready0, ov0, lt0, gt0, eq0;
    logic          in_ready1, ov1, lt1, gt1, eq1;
    logic [CW-1:0] cy0, cy1;

    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
        .lt(lt0), .gt(gt0), .eq(eq0), .cycles(cy0)
    );

    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
        .lt(lt1), .gt(gt1), .eq(eq1), .cycles(cy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int lt;
        int gt;
        int eq;
        int n;
        int acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    bit   seen[2];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic ov, input logic l, input logic g,
                       input logic e, input logic [CW-1:0] cy);
        exp_t x;
        if (!ov) begin
            seen[k] = 1'b0;
            return;
        end
        if (!seen[k]) begin
            seen[k] = 1'b1;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                chk($sformatf("d%0d_unexpected_out_valid", k), ov, 0);
                cur[k] = '{lt: l, gt: g, eq: e, n: cy, acc: 0};
                return;
            end
            if (k == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            cur[k] = x;
            chk($sformatf("d%0d_lt", k), l, x.lt);
            chk($sformatf("d%0d_gt", k), g, x.gt);
            chk($sformatf("d%0d_eq", k), e, x.eq);
            chk($sformatf("d%0d_onehot", k), l + g + e, 1);
            chk($sformatf("d%0d_cycles", k), cy, x.n);
            chk($sformatf("d%0d_latency", k), cyc - x.acc, x.n);
        end else begin
            chk($sformatf("d%0d_hold_lt", k), l, cur[k].lt);
            chk($sformatf("d%0d_hold_gt", k), g, cur[k].gt);
            chk($sformatf("d%0d_hold_eq", k), e, cur[k].eq);
            chk($sformatf("d%0d_hold_cycles", k), cy, cur[k].n);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            seen[0] = 1'b0;
            seen[1] = 1'b0;
        end else begin
            mon(0, ov0, lt0, gt0, eq0, cy0);
            mon(1, ov1, lt1, gt1, eq1, cy1);
        end
    end

    // Early-exit cycle count from the position of the highest differing bit.
    function automatic int ee_cycles(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return W - i;
        end
        return W;
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int elt, input int egt, input int eeq,
                         input int n_ee, input bit expect_out);
        int t;
        t = 0;
        @(negedge clk);
        while (!(in_ready0 && in_ready1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("issue_timeout_in_ready", in_ready0 & in_ready1, 1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (expect_out) begin
            q0.push_back('{lt: elt, gt: egt, eq: eeq, n: n_ee, acc: cyc});
            q1.push_back('{lt: elt, gt: egt, eq: eeq, n: W,    acc: cyc});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(in_ready0 && in_ready1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("wait_idle_timeout", in_ready0 & in_ready1, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready0", in_ready0, 1);
        chk("rst_in_ready1", in_ready1, 1);
        chk("rst_out_valid0", ov0, 0);
        chk("rst_out_valid1", ov1, 0);
        chk("rst_flags0", {lt0, gt0, eq0}, 0);
        chk("rst_flags1", {lt1, gt1, eq1}, 0);
        chk("rst_cycles0", cy0, 0);
        chk("rst_cycles1", cy1, 0);

        // Directed: equal, MSB difference, LSB-only difference.
        issue(8'hA5, 8'hA5, 0, 0, 1, 8, 1);
        issue(8'h80, 8'h7F, 0, 1, 0, 1, 1);
        issue(8'h12, 8'h13, 1, 0, 0, 8, 1);
        wait_idle();

        // Backpressure: result held, new operands refused.
        out_ready = 1'b0;
        issue(8'h80, 8'h7F, 0, 1, 0, 1, 1);
        t = 0;
        while (!(ov0 && ov1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("bp_done_timeout", ov0 & ov1, 1);
        a        = 8'h33;
        b        = 8'h44;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready0", in_ready0, 0);
            chk("bp_in_ready1", in_ready1, 0);
            chk("bp_out_valid0", ov0, 1);
            chk("bp_out_valid1", ov1, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        issue(8'h33, 8'h44, 1, 0, 0, 2, 1);
        wait_idle();

        // Reset sampled at the third SHIFT edge aborts the operation.
        issue(8'h0F, 8'h0E, 0, 1, 0, 8, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready0", in_ready0, 1);
        chk("abort_in_ready1", in_ready1, 1);
        chk("abort_flags0", {lt0, gt0, eq0}, 0);
        chk("abort_flags1", {lt1, gt1, eq1}, 0);
        chk("abort_out_valid1", ov1, 0);
        repeat (12) @(negedge clk);

        // Back-to-back random pairs, every fifth one forced equal.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            if (i % 5 == 0) rb = ra;
            issue(ra, rb, int'(ra < rb), int'(ra > rb), int'(ra == rb), ee_cycles(ra, rb), 1);
        end

        t = 0;
        while ((q0.size() + q1.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drain", q0.size() + q1.size(), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
